// File: rtl/nec_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nec_bus_ctrl
// Description : Bus-cycle controller for an external NEC V30/V33 CPU.
//               Generates NEC_CLK, synchronizes the CPU strobes and AD bus,
//               converts each CPU bus cycle into one req/ack transaction on
//               the internal memory/IO port, and sequences NEC_READY plus
//               the AD output drivers.
//               Optional feature macro: BUS_TIMEOUT_EN (forced completion of
//               a transaction that is not acknowledged within TIMEOUT cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module nec_bus_ctrl #(
    parameter int CLK_DIV = 4,      // clk_sys cycles per nec_clk period, even, >= 4
    parameter int TIMEOUT = 255     // clk_sys cycles from mem_req to forced completion
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    output logic        nec_clk,
    input  logic [19:0] nec_ad_in,
    output logic [15:0] nec_ad_out,
    output logic        nec_ad_oe,
    input  logic        nec_astb,
    input  logic        nec_rd_n,
    input  logic        nec_wr_n,
    input  logic        nec_io_n,
    input  logic        nec_ube_n,
    input  logic        nec_intak_n,
    output logic        nec_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [19:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [7:0]  int_vector,
    output logic        busy,
    output logic        err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int                 c_DIV_W    = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV / 2);

    // Bit positions inside the packed strobe vector
    localparam int c_ASTB  = 5;
    localparam int c_RD    = 4;
    localparam int c_WR    = 3;
    localparam int c_IO    = 2;
    localparam int c_UBE   = 1;
    localparam int c_INTAK = 0;

    // Idle levels: ASTB low, all active-low strobes high
    localparam logic [5:0] c_STRB_IDLE = 6'b011111;

    // Kind of the cycle in progress, selects the strobe that ends DONE
    localparam logic [1:0] c_KIND_RD    = 2'd0;
    localparam logic [1:0] c_KIND_WR    = 2'd1;
    localparam logic [1:0] c_KIND_INTAK = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WDAT = 3'd2,
        S_REQ  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_nec_clk;

    logic [5:0]  w_strb_in;
    logic [5:0]  r_strb_s1;
    logic [5:0]  r_strb_s2;
    logic [5:0]  r_strb_d;
    logic [5:0]  w_fall;
    logic [5:0]  w_rise;
    logic [19:0] r_ad_s1;
    logic [19:0] r_ad_s2;

    state_t      r_state;
    logic [1:0]  r_kind;
    logic        w_done_rise;
    logic [1:0]  w_latch_be;

    logic        r_nec_ready;
    logic        r_nec_ad_oe;
    logic [15:0] r_nec_ad_out;
    logic        r_mem_req;
    logic        r_mem_we;
    logic        r_mem_io;
    logic [19:0] r_mem_addr;
    logic [1:0]  r_mem_be;
    logic [15:0] r_mem_wdata;
    logic        r_busy;

`ifdef BUS_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_to_expire;
    logic              r_err;

    // Last REQ cycle before forced completion (mem_req high for TIMEOUT cycles)
    assign w_to_expire = (r_to_cnt == c_TO_LAST);
    assign err         = r_err;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // nec_clk divider: counter wraps at CLK_DIV-1, clock toggles at 0 and half
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_nec_clk <= 1'b0;
        end else begin
            if (r_div_cnt == c_DIV_LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if ((r_div_cnt == '0) || (r_div_cnt == c_DIV_HALF)) begin
                r_nec_clk <= ~r_nec_clk;
            end
        end
    end

    // ------------------------------------------------------------------
    // Strobe synchronizers and matching AD pipeline, plus edge-detect stage
    // ------------------------------------------------------------------
    assign w_strb_in = {nec_astb, nec_rd_n, nec_wr_n, nec_io_n, nec_ube_n, nec_intak_n};

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_strb_s1 <= c_STRB_IDLE;
            r_strb_s2 <= c_STRB_IDLE;
            r_strb_d  <= c_STRB_IDLE;
            r_ad_s1   <= '0;
            r_ad_s2   <= '0;
        end else begin
            r_strb_s1 <= w_strb_in;
            r_strb_s2 <= r_strb_s1;
            r_strb_d  <= r_strb_s2;
            r_ad_s1   <= nec_ad_in;
            r_ad_s2   <= r_ad_s1;
        end
    end

    assign w_fall     = r_strb_d & ~r_strb_s2;
    assign w_rise     = ~r_strb_d & r_strb_s2;
    assign w_latch_be = {~r_strb_s2[c_UBE], ~r_ad_s2[0]};

    // The strobe that opened the data phase is the one whose release ends it
    always_comb begin
        w_done_rise = 1'b0;
        case (r_kind)
            c_KIND_RD: w_done_rise = w_rise[c_RD];
            c_KIND_WR: w_done_rise = w_rise[c_WR];
            default:   w_done_rise = w_rise[c_INTAK];
        endcase
    end

    // ------------------------------------------------------------------
    // Bus-cycle FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_kind       <= c_KIND_RD;
            r_nec_ready  <= 1'b0;
            r_nec_ad_oe  <= 1'b0;
            r_nec_ad_out <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_io     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            r_to_cnt     <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
`ifdef BUS_TIMEOUT_EN
            r_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_fall[c_ASTB]) begin
                        r_mem_addr <= r_ad_s2;
                        r_mem_io   <= ~r_strb_s2[c_IO];
                        r_mem_be   <= w_latch_be;
                        r_busy     <= 1'b1;
                        r_state    <= S_ADDR;
                    end
                end

                S_ADDR: begin
                    if (w_fall[c_ASTB]) begin
                        // A fresh address strobe replaces the latched address
                        r_mem_addr <= r_ad_s2;
                        r_mem_io   <= ~r_strb_s2[c_IO];
                        r_mem_be   <= w_latch_be;
                    end else if (!r_strb_s2[c_RD]) begin
                        r_kind    <= c_KIND_RD;
                        r_mem_we  <= 1'b0;
                        r_mem_req <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                        r_to_cnt  <= '0;
`endif
                        r_state   <= S_REQ;
                    end else if (!r_strb_s2[c_WR]) begin
                        r_kind  <= c_KIND_WR;
                        r_state <= S_WDAT;
                    end else if (!r_strb_s2[c_INTAK]) begin
                        // Interrupt acknowledge is answered locally
                        r_kind       <= c_KIND_INTAK;
                        r_nec_ad_out <= {8'h00, int_vector};
                        r_nec_ad_oe  <= 1'b1;
                        r_nec_ready  <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end

                S_WDAT: begin
                    // Word passed unshifted; the byte enables select the lane
                    r_mem_wdata <= r_ad_s2[15:0];
                    r_mem_we    <= 1'b1;
                    r_mem_req   <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                    r_to_cnt    <= '0;
`endif
                    r_state     <= S_REQ;
                end

                S_REQ: begin
                    if (mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_nec_ready <= 1'b1;
                        if (r_kind == c_KIND_RD) begin
                            r_nec_ad_out <= mem_rdata;
                            r_nec_ad_oe  <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (w_to_expire) begin
                        // Ack never came: complete the CPU cycle with all-ones data
                        r_mem_req    <= 1'b0;
                        r_err        <= 1'b1;
                        r_nec_ready  <= 1'b1;
                        r_nec_ad_out <= 16'hFFFF;
                        if (r_kind == c_KIND_RD) begin
                            r_nec_ad_oe <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end

                S_DONE: begin
                    if (w_done_rise) begin
                        r_nec_ready <= 1'b0;
                        r_nec_ad_oe <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_nec_ready <= 1'b0;
                    r_nec_ad_oe <= 1'b0;
                    r_mem_req   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign nec_clk    = r_nec_clk;
    assign nec_ready  = r_nec_ready;
    assign nec_ad_oe  = r_nec_ad_oe;
    assign nec_ad_out = r_nec_ad_out;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_io     = r_mem_io;
    assign mem_addr   = r_mem_addr;
    assign mem_be     = r_mem_be;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_nec_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nec_bus_ctrl
// Description : Self-checking bench for nec_bus_ctrl. Stimulus pushes the
//               expected memory request and CPU completion into queues; a
//               monitor pops and compares when mem_req / nec_ready rise.
//               Build with BUS_TIMEOUT_EN to also exercise the timeout path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nec_bus_ctrl;

`ifdef BUS_TIMEOUT_EN
    localparam int c_TO = 16;
`else
    localparam int c_TO = 255;
`endif

    logic        clk_sys;
    logic        reset_n;
    logic        nec_clk;
    logic [19:0] nec_ad_in;
    logic [15:0] nec_ad_out;
    logic        nec_ad_oe;
    logic        nec_astb;
    logic        nec_rd_n;
    logic        nec_wr_n;
    logic        nec_io_n;
    logic        nec_ube_n;
    logic        nec_intak_n;
    logic        nec_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_io;
    logic [19:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [7:0]  int_vector;
    logic        busy;
    logic        err;

    typedef struct {
        logic [19:0] addr;
        logic        we;
        logic        io;
        logic [1:0]  be;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        logic        oe;
        logic [15:0] data;
    } cpl_t;

    req_t        req_q[$];
    cpl_t        cpl_q[$];
    int          checks;
    int          failures;
    int          req_cycles;
    int          err_pulses;
    logic        no_ack;
    logic [15:0] resp_data;

    nec_bus_ctrl #(
        .CLK_DIV (4),
        .TIMEOUT (c_TO)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .nec_clk     (nec_clk),
        .nec_ad_in   (nec_ad_in),
        .nec_ad_out  (nec_ad_out),
        .nec_ad_oe   (nec_ad_oe),
        .nec_astb    (nec_astb),
        .nec_rd_n    (nec_rd_n),
        .nec_wr_n    (nec_wr_n),
        .nec_io_n    (nec_io_n),
        .nec_ube_n   (nec_ube_n),
        .nec_intak_n (nec_intak_n),
        .nec_ready   (nec_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_io      (mem_io),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .int_vector  (int_vector),
        .busy        (busy),
        .err         (err)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic [19:0] addr, input logic we, input logic io,
                           input logic [1:0] be, input logic [15:0] wdata);
        req_t r;
        r.addr = addr; r.we = we; r.io = io; r.be = be; r.wdata = wdata;
        req_q.push_back(r);
    endtask

    task automatic exp_cpl(input logic oe, input logic [15:0] data);
        cpl_t c;
        c.oe = oe; c.data = data;
        cpl_q.push_back(c);
    endtask

    function automatic logic cond(input int which);
        case (which)
            0:       return nec_ready;
            1:       return ~busy;
            default: return mem_req;
        endcase
    endfunction

    // Bounded wait on a DUT condition, sampled on the falling edge
    task automatic wait_for(input int which, input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_sys);
            if (cond(which)) return;
        end
        checks++;
        failures++;
        $display("FAIL timeout_%s actual=not_seen required=seen", name);
    endtask

    task automatic cpu_addr(input logic [19:0] addr, input logic ube_n, input logic io_n);
        @(negedge clk_sys);
        nec_ad_in = addr;
        nec_io_n  = io_n;
        nec_ube_n = ube_n;
        nec_astb  = 1'b1;
        repeat (2) @(negedge clk_sys);
        nec_astb = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    // kind: 0 read, 1 write, 2 interrupt acknowledge
    task automatic cpu_cycle(input int kind, input logic [19:0] addr, input logic ube_n,
                             input logic io_n, input logic [15:0] wdata, input logic [15:0] rdata);
        resp_data = rdata;
        cpu_addr(addr, ube_n, io_n);
        case (kind)
            0:       nec_rd_n = 1'b0;
            1:       begin nec_wr_n = 1'b0; nec_ad_in = {4'h0, wdata}; end
            default: nec_intak_n = 1'b0;
        endcase
        wait_for(0, "ready");
        repeat (2) @(negedge clk_sys);
        nec_rd_n    = 1'b1;
        nec_wr_n    = 1'b1;
        nec_intak_n = 1'b1;
        wait_for(1, "idle");
        check("oe_after_cycle", {31'd0, nec_ad_oe}, 32'd0);
        check("ready_after_cycle", {31'd0, nec_ready}, 32'd0);
        nec_io_n  = 1'b1;
        nec_ube_n = 1'b1;
    endtask

    // Memory responder: acks three clocks after the request appears
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk_sys);
            if (mem_req && !no_ack) begin
                repeat (2) @(negedge clk_sys);
                mem_rdata = resp_data;
                mem_ack   = 1'b1;
                @(negedge clk_sys);
                mem_ack = 1'b0;
                @(negedge clk_sys);
            end
        end
    end

    // Monitor: compare requests and completions against the scoreboard queues
    initial begin
        logic prev_req;
        logic prev_rdy;
        req_t r;
        cpl_t c;
        prev_req = 1'b0;
        prev_rdy = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (!reset_n) begin
                prev_req = 1'b0;
                prev_rdy = 1'b0;
            end else begin
                if (mem_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_req actual=addr_%h required=no_request", mem_addr);
                    end else begin
                        r = req_q.pop_front();
                        check("req_addr", {12'd0, mem_addr}, {12'd0, r.addr});
                        check("req_we", {31'd0, mem_we}, {31'd0, r.we});
                        check("req_io", {31'd0, mem_io}, {31'd0, r.io});
                        check("req_be", {30'd0, mem_be}, {30'd0, r.be});
                        if (r.we) check("req_wdata", {16'd0, mem_wdata}, {16'd0, r.wdata});
                        check("ready_low_in_req", {31'd0, nec_ready}, 32'd0);
                    end
                end
                if (nec_ready && !prev_rdy) begin
                    if (cpl_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ready actual=ready_1 required=ready_0");
                    end else begin
                        c = cpl_q.pop_front();
                        check("cpl_oe", {31'd0, nec_ad_oe}, {31'd0, c.oe});
                        if (c.oe) check("cpl_data", {16'd0, nec_ad_out}, {16'd0, c.data});
                    end
                end
                if (mem_req) req_cycles++;
                if (err) err_pulses++;
                prev_req = mem_req;
                prev_rdy = nec_ready;
            end
        end
    end

    initial begin
        int edges;
        checks      = 0;
        failures    = 0;
        req_cycles  = 0;
        err_pulses  = 0;
        no_ack      = 1'b0;
        resp_data   = 16'h0000;
        reset_n     = 1'b0;
        nec_ad_in   = 20'h00000;
        nec_astb    = 1'b0;
        nec_rd_n    = 1'b1;
        nec_wr_n    = 1'b1;
        nec_io_n    = 1'b1;
        nec_ube_n   = 1'b1;
        nec_intak_n = 1'b1;
        int_vector  = 8'h42;

        // Reset state
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_nec_clk", {31'd0, nec_clk}, 32'd0);
        check("rst_ready", {31'd0, nec_ready}, 32'd0);
        check("rst_oe", {31'd0, nec_ad_oe}, 32'd0);
        check("rst_ad_out", {16'd0, nec_ad_out}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we_io", {30'd0, mem_we, mem_io}, 32'd0);
        check("rst_addr", {12'd0, mem_addr}, 32'd0);
        check("rst_be", {30'd0, mem_be}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_busy_err", {30'd0, busy, err}, 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // nec_clk period measured in clk_sys cycles
        edges = 0;
        for (int i = 0; i < 20 && !(nec_clk == 1'b0); i++) @(negedge clk_sys);
        for (int i = 0; i < 20 && !(nec_clk == 1'b1); i++) @(negedge clk_sys);
        for (int i = 0; i < 20 && !(nec_clk == 1'b0); i++) begin @(negedge clk_sys); edges++; end
        for (int i = 0; i < 20 && !(nec_clk == 1'b1); i++) begin @(negedge clk_sys); edges++; end
        check("nec_clk_period", edges, 32'd4);

        // 1: word read
        exp_req(20'h12344, 1'b0, 1'b0, 2'b11, 16'h0000);
        exp_cpl(1'b1, 16'hBEEF);
        cpu_cycle(0, 20'h12344, 1'b0, 1'b1, 16'h0000, 16'hBEEF);

        // 2: odd-byte write
        exp_req(20'h00101, 1'b1, 1'b0, 2'b10, 16'h5A00);
        exp_cpl(1'b0, 16'h0000);
        cpu_cycle(1, 20'h00101, 1'b0, 1'b1, 16'h5A00, 16'h0000);

        // 3: IO low-byte read
        exp_req(20'h00080, 1'b0, 1'b1, 2'b01, 16'h0000);
        exp_cpl(1'b1, 16'h1357);
        cpu_cycle(0, 20'h00080, 1'b1, 1'b0, 16'h0000, 16'h1357);

        // 4: interrupt acknowledge, no memory request
        exp_cpl(1'b1, 16'h0042);
        cpu_cycle(2, 20'h00000, 1'b1, 1'b1, 16'h0000, 16'h0000);

`ifdef BUS_TIMEOUT_EN
        // 6: read without ack is forced to complete
        no_ack     = 1'b1;
        req_cycles = 0;
        err_pulses = 0;
        exp_req(20'h00300, 1'b0, 1'b0, 2'b11, 16'h0000);
        exp_cpl(1'b1, 16'hFFFF);
        cpu_cycle(0, 20'h00300, 1'b0, 1'b1, 16'h0000, 16'h0000);
        check("timeout_req_cycles", req_cycles, 32'd16);
        check("timeout_err_pulses", err_pulses, 32'd1);
        no_ack = 1'b0;
`endif

        // 5: reset during REQ aborts the cycle; the late ack is ignored
        exp_req(20'h00200, 1'b0, 1'b0, 2'b11, 16'h0000);
        resp_data = 16'hDEAD;
        cpu_addr(20'h00200, 1'b0, 1'b1);
        nec_rd_n = 1'b0;
        wait_for(2, "req");
        reset_n = 1'b0;
        @(posedge clk_sys);
        #1;
        check("rstmid_req", {31'd0, mem_req}, 32'd0);
        check("rstmid_ready", {31'd0, nec_ready}, 32'd0);
        check("rstmid_oe", {31'd0, nec_ad_oe}, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk_sys);
        reset_n  = 1'b1;
        nec_rd_n = 1'b1;
        repeat (8) @(negedge clk_sys);
        check("post_ack_busy", {31'd0, busy}, 32'd0);
        check("post_ack_req_ready", {30'd0, mem_req, nec_ready}, 32'd0);

        repeat (4) @(negedge clk_sys);
        check("req_queue_empty", req_q.size(), 32'd0);
        check("cpl_queue_empty", cpl_q.size(), 32'd0);
`ifndef BUS_TIMEOUT_EN
        check("err_never_set", err_pulses, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
